// File: rtl/hc08_tester.sv
// Sequential self-test engine for a quad 2-input AND gate block (HC08).
// Optional Y_IN synchroniser enabled by defining HC08_TESTER_SYNC_EN.
module hc08_tester #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  output logic [4:1] A_OUT,
  output logic [4:1] B_OUT,
  input  logic [4:1] Y_IN,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [8:0] ERR_CNT,
  output logic [4:1] FAIL_MASK
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  logic [4:1] y_s;

`ifdef HC08_TESTER_SYNC_EN
  localparam int unsigned SETTLE_EFF = SETTLE + 2;

  logic [4:1] y_meta;
  logic [4:1] y_sync;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y_meta <= '0;
      y_sync <= '0;
    end else begin
      y_meta <= Y_IN;
      y_sync <= y_meta;
    end
  end

  assign y_s = y_sync;
`else
  localparam int unsigned SETTLE_EFF = SETTLE;

  assign y_s = Y_IN;
`endif

  localparam logic [8:0] RELOAD = 9'(SETTLE_EFF - 1);

  state_t     state;
  logic [7:0] vec;
  logic [8:0] cnt;
  logic [4:1] expv;
  logic [4:1] mism;

  // Drive values come straight from the vector register, so pins never glitch.
  assign A_OUT = vec[7:4];
  assign B_OUT = vec[3:0];
  assign expv  = A_OUT & B_OUT;
  assign mism  = y_s ^ expv;
  assign PASS  = DONE & (ERR_CNT == '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      vec       <= '0;
      cnt       <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR_CNT   <= '0;
      FAIL_MASK <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state     <= S_DRIVE;
            vec       <= '0;
            cnt       <= RELOAD;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            ERR_CNT   <= '0;
            FAIL_MASK <= '0;
          end
        end
        S_DRIVE: begin
          if (cnt == '0) begin
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt - 9'd1;
          end
        end
        S_SAMPLE: begin
          // Saturate at 256 so a fully broken block reads as all-vectors-failed.
          if ((mism != '0) && (ERR_CNT != 9'd256)) begin
            ERR_CNT <= ERR_CNT + 9'd1;
          end
          FAIL_MASK <= FAIL_MASK | mism;
          if (vec == 8'hFF) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            vec   <= vec + 8'd1;
            cnt   <= RELOAD;
            state <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hc08_tester.sv
// Self-checking bench for hc08_tester: table of fault modes plus random faults,
// mid-run START and mid-run reset sequences.
module tb_hc08_tester;

  localparam int unsigned SETTLE = 2;
`ifdef HC08_TESTER_SYNC_EN
  localparam int unsigned SETTLE_EFF = SETTLE + 2;
`else
  localparam int unsigned SETTLE_EFF = SETTLE;
`endif
  localparam int RUN_CYCLES = 256 * (SETTLE_EFF + 1);
  localparam int LIMIT = RUN_CYCLES + 200;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic [4:1] A_OUT;
  logic [4:1] B_OUT;
  logic [4:1] Y_IN;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [8:0] ERR_CNT;
  logic [4:1] FAIL_MASK;

  // Fault model: HC08 output = ideal AND, XOR a per-vector flip pattern.
  logic [3:0] flip [256];

  int errors = 0;
  int checks = 0;

  hc08_tester #(.SETTLE(SETTLE)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .START(START),
    .A_OUT(A_OUT),
    .B_OUT(B_OUT),
    .Y_IN(Y_IN),
    .BUSY(BUSY),
    .DONE(DONE),
    .PASS(PASS),
    .ERR_CNT(ERR_CNT),
    .FAIL_MASK(FAIL_MASK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign Y_IN = (A_OUT & B_OUT) ^ flip[{A_OUT, B_OUT}];

  typedef struct {
    string name;
    int    mode;
    int    exp_err;
    int    exp_mask;
    int    exp_pass;
  } row_t;

  row_t rows [6];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Build flip table for a fault mode from its gate-level description.
  task automatic set_mode(input int mode);
    for (int v = 0; v < 256; v++) begin
      logic [3:0] a, b, g;
      a = 4'(v >> 4);
      b = 4'(v);
      g = a & b;
      case (mode)
        0: flip[v] = 4'h0;
        1: flip[v] = ~g & 4'b0100;             // gate 3 stuck-at-1
        2: flip[v] = g;                        // all outputs stuck-at-0
        3: flip[v] = 4'hF;                     // every gate inverted
        4: flip[v] = g & 4'b0001;              // gate 1 stuck-at-0
        default: flip[v] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      endcase
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  // Run one test; inject_vec >= 0 pulses START when that vector is on the pins.
  task automatic run(input string name, input int inject_vec, output int cycles);
    bit injected;
    bit busy_prev;
    injected = 0;
    pulse_start();
    check({name, "_busy_rise"}, int'(BUSY), 1);
    check({name, "_done_clr"}, int'(DONE), 0);
    cycles = 0;
    busy_prev = BUSY;
    while (!DONE && cycles < LIMIT) begin
      if (inject_vec >= 0 && !injected && int'({A_OUT, B_OUT}) == inject_vec) begin
        START = 1'b1;
        injected = 1;
      end else begin
        START = 1'b0;
      end
      busy_prev = BUSY;
      @(posedge CLK);
      #1;
      cycles++;
    end
    START = 1'b0;
    if (inject_vec >= 0) check({name, "_injected"}, int'(injected), 1);
    check({name, "_cycles"}, cycles, RUN_CYCLES);
    check({name, "_busy_prev"}, int'(busy_prev), 1);
    check({name, "_busy_fall"}, int'(BUSY), 0);
  endtask

  initial begin
    int cyc;
    int exp_err;
    int exp_mask;

    rows[0] = '{"good",      0, 0,   0,  1};
    rows[1] = '{"g3_stuck1", 1, 192, 4,  0};
    rows[2] = '{"stuck0",    2, 175, 15, 0};
    rows[3] = '{"inverted",  3, 256, 15, 0};
    rows[4] = '{"g1_stuck0", 4, 64,  1,  0};
    rows[5] = '{"random",    5, 0,   0,  0};

    START = 1'b0;
    RST_N = 1'b0;
    set_mode(0);
    #23;
    check("rst_a", int'(A_OUT), 0);
    check("rst_b", int'(B_OUT), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_pass", int'(PASS), 0);
    check("rst_err", int'(ERR_CNT), 0);
    check("rst_mask", int'(FAIL_MASK), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1 check("idle_done", int'(DONE), 0);

    for (int r = 0; r < 6; r++) begin
      set_mode(rows[r].mode);
      exp_err  = rows[r].exp_err;
      exp_mask = rows[r].exp_mask;
      if (rows[r].mode == 5) begin
        exp_err  = 0;
        exp_mask = 0;
        for (int v = 0; v < 256; v++) begin
          if (flip[v] != 4'h0) exp_err++;
          exp_mask |= int'(flip[v]);
        end
      end
      run(rows[r].name, -1, cyc);
      check({rows[r].name, "_err"}, int'(ERR_CNT), exp_err);
      check({rows[r].name, "_mask"}, int'(FAIL_MASK), exp_mask);
      check({rows[r].name, "_pass"}, int'(PASS), (rows[r].mode == 5) ? int'(exp_err == 0) : rows[r].exp_pass);
      check({rows[r].name, "_a_end"}, int'(A_OUT), 15);
      repeat (5) @(posedge CLK);
      #1 check({rows[r].name, "_done_hold"}, int'(DONE), 1);
      check({rows[r].name, "_err_hold"}, int'(ERR_CNT), exp_err);
    end

    // START during a run is ignored; the run still completes on schedule.
    set_mode(1);
    run("restart_ignored", 40, cyc);
    check("restart_err", int'(ERR_CNT), 192);
    check("restart_mask", int'(FAIL_MASK), 4);

    // Asynchronous reset mid-run, then a clean full run.
    set_mode(3);
    pulse_start();
    for (int i = 1; i < 300; i++) begin
      @(posedge CLK);
    end
    #2 RST_N = 1'b0;
    #1;
    check("midrst_a", int'(A_OUT), 0);
    check("midrst_b", int'(B_OUT), 0);
    check("midrst_busy", int'(BUSY), 0);
    check("midrst_done", int'(DONE), 0);
    check("midrst_err", int'(ERR_CNT), 0);
    check("midrst_mask", int'(FAIL_MASK), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1 check("midrst_still_idle", int'(BUSY), 0);
    set_mode(0);
    run("after_rst", -1, cyc);
    check("after_rst_pass", int'(PASS), 1);
    check("after_rst_err", int'(ERR_CNT), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
